// File: rtl/stream_upscale_2x.sv
// ---------------------------------------------------------------------------
// stream_upscale_2x
//   Nearest-neighbour 2x upscaler sitting between the RGB444 frame streamer
//   and the VGA sink. Each input pixel is sent twice on its output row. Each
//   input row is sent twice: the first copy goes out live as pixels arrive,
//   and the second copy is replayed from a one-line buffer. Each 4-bit
//   channel c is widened to {c,c} and packed into a 10-bit VGA channel with
//   two zero LSBs.
//
// Ports
//   clk                 single clock for all logic
//   reset_n             asynchronous, active-low reset
//   snk_data            input pixel {R[11:8],G[7:4],B[3:0]}
//   snk_startofpacket   first pixel of an input frame
//   snk_endofpacket     last pixel of an input frame (not used; frame end
//                       comes from the counters)
//   snk_valid/ready     Avalon-ST sink handshake
//   src_data            {R8,2'b00,G8,2'b00,B8,2'b00}
//   src_startofpacket   first beat of an output frame
//   src_endofpacket     last beat of an output frame
//   src_valid/ready     Avalon-ST source handshake
// ---------------------------------------------------------------------------
module stream_upscale_2x #(
    parameter int IN_WIDTH    = 320,
    parameter int IN_HEIGHT   = 240,
    parameter int COLOUR_BITS = 12
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [COLOUR_BITS-1:0] snk_data,
    input  logic                   snk_startofpacket,
    input  logic                   snk_endofpacket,
    input  logic                   snk_valid,
    output logic                   snk_ready,
    output logic [29:0]            src_data,
    output logic                   src_startofpacket,
    output logic                   src_endofpacket,
    output logic                   src_valid,
    input  logic                   src_ready
);

    localparam int XW  = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
    localparam int OXW = $clog2(2 * IN_WIDTH);
    localparam int YW  = (IN_HEIGHT > 1) ? $clog2(IN_HEIGHT) : 1;
    localparam int RW  = $clog2(IN_WIDTH + 1);

    localparam logic [XW-1:0]  X_LAST    = XW'(IN_WIDTH - 1);
    localparam logic [OXW-1:0] OX_LAST   = OXW'(2 * IN_WIDTH - 1);
    localparam logic [OXW-1:0] OX_PENULT = OXW'(2 * IN_WIDTH - 2);
    localparam logic [YW-1:0]  Y_LAST    = YW'(IN_HEIGHT - 1);
    localparam logic [RW-1:0]  RD_END    = RW'(IN_WIDTH);

    localparam logic [1:0] S_SYNC   = 2'd0;
    localparam logic [1:0] S_LIVE   = 2'd1;
    localparam logic [1:0] S_REPLAY = 2'd2;

    function automatic logic [29:0] expand_rgb(input logic [11:0] p);
        return {p[11:8], p[11:8], 2'b00,
                p[7:4],  p[7:4],  2'b00,
                p[3:0],  p[3:0],  2'b00};
    endfunction

    logic [1:0]       state;
    logic             active;
    logic [XW-1:0]    in_x;
    logic [YW-1:0]    in_y;
    logic [OXW-1:0]   out_x;
    logic [RW-1:0]    rd_idx;

    logic [COLOUR_BITS-1:0] line_buf [IN_WIDTH];
    logic [COLOUR_BITS-1:0] rd_pix_p0;
    logic                   rd_vld_p0;

    logic [29:0]      data_p1;
    logic             vld_p1;
    logic             sop_p1;
    logic             eop_p1;

    logic             out_fire;
    logic             live_slot;
    logic             in_take;
    logic             sync_take;
    logic             live_take;
    logic             restart;
    logic             wr_en;
    logic [XW-1:0]    wr_addr;
    logic             live_end;
    logic             rep_end;
    logic             rep_slot;
    logic             rd_en;
    logic [XW-1:0]    rd_addr;
    logic             unused_eop;

    assign unused_eop = snk_endofpacket;

    assign out_fire  = vld_p1 && src_ready;
    // The output register doubles as the hold register: it is free for a new
    // pixel when empty or when its second copy leaves this cycle. The last
    // beat of a row never frees it, because the replay comes next.
    assign live_slot = !vld_p1 || (out_fire && out_x[0] && (out_x != OX_LAST));
    assign snk_ready = active && ((state == S_SYNC) ||
                                  ((state == S_LIVE) && live_slot));

    assign in_take   = snk_valid && snk_ready;
    assign sync_take = in_take && (state == S_SYNC) && snk_startofpacket;
    assign live_take = in_take && (state == S_LIVE);
    assign restart   = sync_take || (live_take && snk_startofpacket);
    assign wr_en     = sync_take || live_take;
    assign wr_addr   = restart ? '0 : in_x;

    assign live_end  = out_fire && (state == S_LIVE)   && (out_x == OX_LAST);
    assign rep_end   = out_fire && (state == S_REPLAY) && (out_x == OX_LAST);
    assign rep_slot  = (state == S_REPLAY) && rd_vld_p0 &&
                       (!vld_p1 || (out_fire && out_x[0] && (out_x != OX_LAST)));
    // Buffer entry 0 is fetched while the last live beat leaves, so the
    // replay row starts after a single bubble; later entries are prefetched
    // while the current pixel is being sent twice.
    assign rd_en     = live_end ||
                       ((state == S_REPLAY) && (rd_idx != RD_END) &&
                        (!rd_vld_p0 || rep_slot));
    assign rd_addr   = live_end ? '0 : XW'(rd_idx);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active <= 1'b0;
        end else begin
            active <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            line_buf[wr_addr] <= snk_data;
        end
    end

    // p0: registered line-buffer read
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_pix_p0 <= line_buf[rd_addr];
        end
    end

    // p1: output/hold register, counters and state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_SYNC;
            in_x      <= '0;
            in_y      <= '0;
            out_x     <= '0;
            rd_idx    <= '0;
            rd_vld_p0 <= 1'b0;
            data_p1   <= '0;
            vld_p1    <= 1'b0;
            sop_p1    <= 1'b0;
            eop_p1    <= 1'b0;
        end else begin
            if (wr_en) begin
                data_p1 <= expand_rgb(snk_data);
                vld_p1  <= 1'b1;
                sop_p1  <= restart;
                eop_p1  <= 1'b0;
            end else if (rep_slot) begin
                data_p1 <= expand_rgb(rd_pix_p0);
                vld_p1  <= 1'b1;
                sop_p1  <= 1'b0;
                eop_p1  <= 1'b0;
            end else if (out_fire) begin
                if (out_x[0]) begin
                    vld_p1 <= 1'b0;
                    sop_p1 <= 1'b0;
                    eop_p1 <= 1'b0;
                end else begin
                    // Moving to the second copy: sop only ever marks the
                    // first copy, eop only the second copy of the last pixel
                    // of the last replayed row.
                    sop_p1 <= 1'b0;
                    eop_p1 <= (state == S_REPLAY) && (out_x == OX_PENULT) &&
                              (in_y == Y_LAST);
                end
            end

            if (restart) begin
                out_x <= '0;
            end else if (out_fire) begin
                out_x <= (out_x == OX_LAST) ? '0 : out_x + 1'b1;
            end

            if (wr_en) begin
                in_x <= (wr_addr == X_LAST) ? '0 : wr_addr + 1'b1;
            end

            if (live_end) begin
                rd_idx <= RW'(1);
            end else if (rd_en) begin
                rd_idx <= rd_idx + 1'b1;
            end

            if (rd_en) begin
                rd_vld_p0 <= 1'b1;
            end else if (rep_slot) begin
                rd_vld_p0 <= 1'b0;
            end

            case (state)
                S_SYNC: begin
                    if (sync_take) begin
                        state <= S_LIVE;
                        in_y  <= '0;
                    end
                end
                S_LIVE: begin
                    if (restart) begin
                        in_y <= '0;
                    end else if (live_end) begin
                        state <= S_REPLAY;
                    end
                end
                S_REPLAY: begin
                    if (rep_end) begin
                        if (in_y == Y_LAST) begin
                            state <= S_SYNC;
                            in_y  <= '0;
                        end else begin
                            state <= S_LIVE;
                            in_y  <= in_y + 1'b1;
                        end
                    end
                end
                default: state <= S_SYNC;
            endcase
        end
    end

    assign src_data          = data_p1;
    assign src_valid         = vld_p1;
    assign src_startofpacket = sop_p1;
    assign src_endofpacket   = eop_p1;

endmodule

// File: tb/tb_stream_upscale_2x.sv
module tb_stream_upscale_2x;

    localparam int W = 4;
    localparam int H = 3;
    localparam int NPIX = W * H;
    localparam int NBEAT = 4 * W * H;

    typedef struct {
        logic [11:0] d;
        bit          sop;
        bit          eop;
    } in_beat_t;

    typedef struct {
        logic [29:0] d;
        bit          sop;
        bit          eop;
    } out_beat_t;

    logic        clk;
    logic        reset_n;
    logic [11:0] snk_data;
    logic        snk_startofpacket;
    logic        snk_endofpacket;
    logic        snk_valid;
    logic        snk_ready;
    logic [29:0] src_data;
    logic        src_startofpacket;
    logic        src_endofpacket;
    logic        src_valid;
    logic        src_ready;

    int total = 0;
    int bad = 0;
    int rdy_pct = 100;
    bit chk_replay = 0;

    in_beat_t  in_q[$];
    out_beat_t exp_q[$];
    out_beat_t got_q[$];

    bit          prev_stall = 0;
    logic [29:0] prev_d;
    logic        prev_sop;
    logic        prev_eop;

    stream_upscale_2x #(
        .IN_WIDTH(W),
        .IN_HEIGHT(H),
        .COLOUR_BITS(12)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .snk_data(snk_data),
        .snk_startofpacket(snk_startofpacket),
        .snk_endofpacket(snk_endofpacket),
        .snk_valid(snk_valid),
        .snk_ready(snk_ready),
        .src_data(src_data),
        .src_startofpacket(src_startofpacket),
        .src_endofpacket(src_endofpacket),
        .src_valid(src_valid),
        .src_ready(src_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // {c,c} is c*17; channels land at bit offsets 22, 12 and 2.
    function automatic logic [29:0] model_px(input logic [11:0] p);
        int r;
        int g;
        int b;
        r = int'(p[11:8]) * 17;
        g = int'(p[7:4]) * 17;
        b = int'(p[3:0]) * 17;
        return 30'((r << 22) | (g << 12) | (b << 2));
    endfunction

    // Reference: walk the accepted input beats in order and emit what the
    // upscaler must produce for them.
    task automatic build_exp();
        bit          synced;
        bit          first;
        int          x;
        int          y;
        logic [11:0] row [W];
        out_beat_t   ob;
        exp_q.delete();
        synced = 0;
        first = 0;
        x = 0;
        y = 0;
        foreach (in_q[i]) begin
            if (!synced) begin
                if (!in_q[i].sop) continue;
                synced = 1;
                x = 0;
                y = 0;
                first = 1;
            end else if (in_q[i].sop) begin
                x = 0;
                y = 0;
                first = 1;
            end
            row[x] = in_q[i].d;
            for (int c = 0; c < 2; c++) begin
                ob.d = model_px(in_q[i].d);
                ob.sop = first && (c == 0);
                ob.eop = 0;
                exp_q.push_back(ob);
            end
            first = 0;
            if (x == W - 1) begin
                for (int k = 0; k < 2 * W; k++) begin
                    ob.d = model_px(row[k / 2]);
                    ob.sop = 0;
                    ob.eop = (y == H - 1) && (k == 2 * W - 1);
                    exp_q.push_back(ob);
                end
                x = 0;
                if (y == H - 1) synced = 0;
                else y++;
            end else begin
                x++;
            end
        end
    endtask

    // mode 0: base+1, base+2, ...; mode 1: constant base; mode 2: random
    task automatic add_frame(input int mode, input logic [11:0] base, input int count);
        in_beat_t b;
        for (int i = 0; i < count; i++) begin
            case (mode)
                0: b.d = base + 12'(i + 1);
                1: b.d = base;
                default: b.d = 12'($urandom);
            endcase
            b.sop = (i == 0);
            b.eop = (i == NPIX - 1);
            in_q.push_back(b);
        end
    endtask

    task automatic add_junk(input int n);
        in_beat_t b;
        for (int i = 0; i < n; i++) begin
            b.d = 12'($urandom);
            b.sop = 0;
            b.eop = ($urandom_range(1) == 1);
            in_q.push_back(b);
        end
    endtask

    task automatic drive_inputs(input int vpct);
        int guard;
        guard = 0;
        while (in_q.size() > 0 && guard < 5000) begin
            @(posedge clk);
            #1;
            snk_valid = ($urandom_range(99) < vpct);
            snk_data = in_q[0].d;
            snk_startofpacket = in_q[0].sop;
            snk_endofpacket = in_q[0].eop;
            @(negedge clk);
            if (snk_valid && snk_ready) void'(in_q.pop_front());
            guard++;
        end
        @(posedge clk);
        #1;
        snk_valid = 1'b0;
        snk_startofpacket = 1'b0;
        snk_endofpacket = 1'b0;
        chk("in_drained", in_q.size(), 0);
    endtask

    task automatic run_seq(input int vpct, input int rpct, input string tag);
        int guard;
        int n;
        rdy_pct = rpct;
        build_exp();
        got_q.delete();
        drive_inputs(vpct);
        guard = 0;
        while (got_q.size() < exp_q.size() && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        repeat (20) @(negedge clk);
        chk({tag, "_len"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk({tag, "_data"}, 32'(got_q[i].d), 32'(exp_q[i].d));
            chk({tag, "_sop"}, 32'(got_q[i].sop), 32'(exp_q[i].sop));
            chk({tag, "_eop"}, 32'(got_q[i].eop), 32'(exp_q[i].eop));
        end
        rdy_pct = 100;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            src_ready = ($urandom_range(99) < rdy_pct);
        end
    end

    // Output monitor: collects transferred beats and checks that a stalled
    // beat does not change.
    always @(negedge clk) begin
        out_beat_t ob;
        if (!reset_n) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                chk("stall_vld", 32'(src_valid), 32'd1);
                chk("stall_data", 32'(src_data), 32'(prev_d));
                chk("stall_sop", 32'(src_startofpacket), 32'(prev_sop));
                chk("stall_eop", 32'(src_endofpacket), 32'(prev_eop));
            end
            if (src_valid && src_ready) begin
                if (chk_replay && (((got_q.size() / (2 * W)) % 2) == 1))
                    chk("replay_ready", 32'(snk_ready), 32'd0);
                ob.d = src_data;
                ob.sop = src_startofpacket;
                ob.eop = src_endofpacket;
                got_q.push_back(ob);
            end
            prev_stall = src_valid && !src_ready;
            prev_d = src_data;
            prev_sop = src_startofpacket;
            prev_eop = src_endofpacket;
        end
    end

    initial begin
        int cnt;
        int guard;
        int eop_at;
        reset_n = 1'b0;
        snk_data = '0;
        snk_startofpacket = 1'b0;
        snk_endofpacket = 1'b0;
        snk_valid = 1'b0;
        src_ready = 1'b1;

        repeat (3) @(negedge clk);
        chk("rst_snk_ready", 32'(snk_ready), 32'd0);
        chk("rst_src_valid", 32'(src_valid), 32'd0);
        chk("rst_sop", 32'(src_startofpacket), 32'd0);
        chk("rst_eop", 32'(src_endofpacket), 32'd0);
        chk("rst_data", 32'(src_data), 32'd0);
        @(posedge clk);
        #3;
        reset_n = 1'b1;
        repeat (2) @(posedge clk);

        // Sequential frame at full rate
        add_frame(0, 12'h000, NPIX);
        chk_replay = 1;
        run_seq(100, 100, "t1");
        chk_replay = 0;
        chk("t1_count", got_q.size(), NBEAT);
        cnt = 0;
        eop_at = -1;
        foreach (got_q[i]) begin
            if (got_q[i].sop) cnt++;
            if (got_q[i].eop) eop_at = i;
        end
        chk("t1_sop_count", cnt, 1);
        chk("t1_eop_pos", eop_at, NBEAT - 1);
        if (got_q.size() > 8) begin
            chk("t1_b0_sop", 32'(got_q[0].sop), 32'd1);
            chk("t1_row1_first", 32'(got_q[8].d), 32'(model_px(12'h001)));
        end

        // Constant-colour frames
        add_frame(1, 12'hF5A, NPIX);
        run_seq(100, 100, "t2a");
        if (got_q.size() > 0) chk("t2_f5a", 32'(got_q[0].d), 32'h3FC552A8);
        add_frame(1, 12'h000, NPIX);
        run_seq(100, 100, "t2b");
        if (got_q.size() > 5) chk("t2_zero", 32'(got_q[5].d), 32'h0);

        // Same sequential frame under random stalls on both sides
        add_frame(0, 12'h000, NPIX);
        run_seq(70, 50, "t3");

        // Junk before the first sop is dropped
        add_junk(3);
        add_frame(0, 12'h000, NPIX);
        run_seq(100, 100, "t4");
        chk("t4_count", got_q.size(), NBEAT);

        // Frame abandoned after 5 pixels by a new sop
        add_frame(0, 12'h100, 5);
        add_frame(0, 12'h200, NPIX);
        run_seq(70, 60, "t5");
        chk("t5_count", got_q.size(), 4 * W + 2 + NBEAT);
        if (got_q.size() > 4 * W + 2) begin
            chk("t5_new_sop", 32'(got_q[4 * W + 2].sop), 32'd1);
            chk("t5_new_data", 32'(got_q[4 * W + 2].d), 32'(model_px(12'h201)));
            chk("t5_no_eop", 32'(got_q[4 * W + 1].eop), 32'd0);
        end

        // Random frames back to back with random stalls
        add_frame(2, 12'h000, NPIX);
        add_frame(2, 12'h000, NPIX);
        run_seq(70, 50, "trnd");

        // Reset in the middle of the last replayed row
        rdy_pct = 100;
        add_frame(2, 12'h000, NPIX);
        build_exp();
        got_q.delete();
        drive_inputs(100);
        guard = 0;
        while (got_q.size() < NBEAT - 4 && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        chk("t6_reached", 32'(got_q.size() >= NBEAT - 4), 32'd1);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("t6_src_valid", 32'(src_valid), 32'd0);
        chk("t6_snk_ready", 32'(snk_ready), 32'd0);
        chk("t6_sop", 32'(src_startofpacket), 32'd0);
        chk("t6_eop", 32'(src_endofpacket), 32'd0);
        chk("t6_data", 32'(src_data), 32'd0);
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            chk("t6_prefix", 32'(got_q[i].d), 32'(exp_q[i].d));
        @(posedge clk);
        #3;
        reset_n = 1'b1;
        add_junk(3);
        add_frame(2, 12'h000, NPIX);
        run_seq(70, 70, "t6_post");
        chk("t6_post_count", got_q.size(), NBEAT);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
